adc_sample_framer: RTL and testbench

Sample buffer and word framer directly upstream of the SPI slave serializer. It accepts 12-bit conversions from the ADC driver, tagged with the hydrophone channel. Each conversion is packed into a 16-bit word and queued in a FIFO. The block presents the head word on a stable 16-bit bus that the SPI slave shifts out, and pops that word only after the SPI transaction that carried it completes, as seen on the chip select.

---
 rtl/adc_sample_framer.sv | 125 ++++++++++++
 tb/tb_adc_sample_framer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_framer.sv
// Packs tagged 12-bit ADC conversions into 16-bit words, queues them in a FIFO and
// presents the head word to the SPI slave, popping it only after the carrying cs cycle ends.
module adc_sample_framer #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] IDLE_WORD = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  input  logic [11:0]              sample_data,
  input  logic [1:0]               sample_ch,
  input  logic                     cs,
  output logic [15:0]              word_out,
  output logic                     word_is_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  function automatic logic [15:0] f_pack(input logic [1:0] ch, input logic ovf,
                                         input logic [11:0] data);
    return {ch, ovf, 1'b0, data};
  endfunction

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf_sticky;
  logic [15:0]   r_word_out;
  logic          r_word_is_data;
  logic          r_cs_meta, r_cs_sync, r_cs_prev;
  state_t        r_state, w_state_nxt;

  logic w_fall, w_rise, w_load, w_pop, w_push, w_drop, w_full, w_empty;

  // cs synchronizer and edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= cs;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  assign w_fall  = r_cs_prev & ~r_cs_sync;
  assign w_rise  = ~r_cs_prev & r_cs_sync;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // IDLE tracks the FIFO head; BUSY freezes the word while the SPI slave shifts it out
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = 1'b1;
        if (w_fall) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_rise) begin
          w_state_nxt = S_IDLE;
          w_pop       = r_word_is_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts when the head is leaving in the same cycle
  assign w_push = sample_valid & (~w_full | w_pop);
  assign w_drop = sample_valid & ~w_push;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= f_pack(sample_ch, r_ovf_sticky | w_drop, sample_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push)      r_ovf_sticky <= 1'b0;
      else if (w_drop) r_ovf_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_out     <= IDLE_WORD;
      r_word_is_data <= 1'b0;
    end else if (w_load) begin
      r_word_out     <= w_empty ? IDLE_WORD : r_mem[r_rd_ptr];
      r_word_is_data <= ~w_empty;
    end
  end

  assign word_out        = r_word_out;
  assign word_is_data    = r_word_is_data;
  assign fifo_count      = r_count;
  assign overflow_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed bench for adc_sample_framer: a vector table of packed words plus
// hand-written sequences for cs freeze/pop, overflow, full-with-pop and reset corners.
module tb_adc_sample_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [1:0]  sample_ch;
  logic        cs;
  logic [15:0] word_out;
  logic        word_is_data;
  logic [4:0]  fifo_count;
  logic        overflow_sticky;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  adc_sample_framer #(.DEPTH(16), .IDLE_WORD(16'hFFFF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .sample_ch      (sample_ch),
    .cs             (cs),
    .word_out       (word_out),
    .word_is_data   (word_is_data),
    .fifo_count     (fifo_count),
    .overflow_sticky(overflow_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [11:0] data);
    sample_ch    = ch;
    sample_data  = data;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Full cs low/high transaction; the frozen word is checked twice while low.
  task automatic cs_cycle(input string name, input logic [15:0] exp_w, input logic exp_d);
    cs = 1'b0;
    repeat (3) tick();
    check({name, "_word"}, 32'(word_out), 32'(exp_w));
    check({name, "_isdata"}, 32'(word_is_data), 32'(exp_d));
    repeat (3) tick();
    check({name, "_word_held"}, 32'(word_out), 32'(exp_w));
    cs = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    vecs[0] = '{2'd0, 12'h000, 16'h0000};
    vecs[1] = '{2'd3, 12'hFFF, 16'hCFFF};
    vecs[2] = '{2'd1, 12'h800, 16'h4800};
    vecs[3] = '{2'd2, 12'h7FF, 16'h87FF};
    vecs[4] = '{2'd1, 12'h123, 16'h4123};
    vecs[5] = '{2'd0, 12'hABC, 16'h0ABC};

    rst_n = 1'b0; cs = 1'b1; sample_valid = 1'b0; sample_data = '0; sample_ch = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_word", 32'(word_out), 32'h0000FFFF);
    check("rst_isdata", 32'(word_is_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow_sticky), 32'd0);

    // single sample latency
    sample_ch = 2'd2; sample_data = 12'h5A3; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("first_count", 32'(fifo_count), 32'd1);
    tick();
    check("first_word", 32'(word_out), 32'h000085A3);
    check("first_isdata", 32'(word_is_data), 32'd1);
    cs_cycle("first_pop", 16'h85A3, 1'b1);
    check("first_count_after", 32'(fifo_count), 32'd0);

    // table-driven packing
    for (int i = 0; i < 6; i++) push(vecs[i].ch, vecs[i].data);
    check("tbl_count", 32'(fifo_count), 32'd6);
    for (int i = 0; i < 6; i++) cs_cycle($sformatf("tbl%0d", i), vecs[i].exp, 1'b1);
    check("tbl_count_after", 32'(fifo_count), 32'd0);

    // empty FIFO transaction: no pop
    cs_cycle("empty", 16'hFFFF, 1'b0);
    check("empty_count", 32'(fifo_count), 32'd0);
    check("empty_word_after", 32'(word_out), 32'h0000FFFF);

    // push during BUSY does not disturb the frozen word
    push(2'd0, 12'hAAA);
    push(2'd1, 12'hBBB);
    repeat (2) tick();
    cs = 1'b0;
    repeat (3) tick();
    check("busy_word_a", 32'(word_out), 32'h00000AAA);
    push(2'd2, 12'hCCC);
    check("busy_count3", 32'(fifo_count), 32'd3);
    check("busy_word_a_held", 32'(word_out), 32'h00000AAA);
    tick();
    cs = 1'b1;
    repeat (4) tick();
    check("busy_word_b", 32'(word_out), 32'h00004BBB);
    check("busy_count2", 32'(fifo_count), 32'd2);
    tick();
    cs_cycle("busy_pop_b", 16'h4BBB, 1'b1);
    cs_cycle("busy_pop_c", 16'h8CCC, 1'b1);
    check("busy_count0", 32'(fifo_count), 32'd0);

    // overflow: 16 accepted, 2 dropped, flag carried into the next accepted word
    for (int i = 0; i < 16; i++) push(2'd0, 12'(12'h100 + i));
    push(2'd3, 12'hDDD);
    push(2'd3, 12'hDDD);
    check("ovf_sticky_set", 32'(overflow_sticky), 32'd1);
    check("ovf_count_full", 32'(fifo_count), 32'd16);
    cs_cycle("ovf_pop0", 16'h0100, 1'b1);
    check("ovf_count15", 32'(fifo_count), 32'd15);
    push(2'd1, 12'h001);
    check("ovf_sticky_clr", 32'(overflow_sticky), 32'd0);
    check("ovf_count16", 32'(fifo_count), 32'd16);
    for (int i = 1; i < 16; i++) cs_cycle($sformatf("ovf_pop%0d", i), 16'(16'h0100 + i), 1'b1);
    cs_cycle("ovf_flagged", 16'h6001, 1'b1);
    check("ovf_drained", 32'(fifo_count), 32'd0);

    // full FIFO, sample arrives on the exact pop cycle
    for (int i = 0; i < 16; i++) push(2'd0, 12'(12'h200 + i));
    cs = 1'b0;
    repeat (3) tick();
    check("fullpop_word", 32'(word_out), 32'h00000200);
    cs = 1'b1;
    repeat (2) tick();
    sample_ch = 2'd2; sample_data = 12'h777; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("fullpop_count", 32'(fifo_count), 32'd16);
    check("fullpop_ovf", 32'(overflow_sticky), 32'd0);
    repeat (3) tick();
    for (int i = 1; i < 16; i++) cs_cycle($sformatf("fullpop%0d", i), 16'(16'h0200 + i), 1'b1);
    cs_cycle("fullpop_new", 16'h8777, 1'b1);
    check("fullpop_drained", 32'(fifo_count), 32'd0);

    // reset while BUSY with 5 entries, cs held low through release
    for (int i = 0; i < 5; i++) push(2'd1, 12'(12'h300 + i));
    tick();
    cs = 1'b0;
    repeat (3) tick();
    check("rstb_word_pre", 32'(word_out), 32'h00004300);
    check("rstb_count_pre", 32'(fifo_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("rstb_word", 32'(word_out), 32'h0000FFFF);
    check("rstb_isdata", 32'(word_is_data), 32'd0);
    check("rstb_count", 32'(fifo_count), 32'd0);
    check("rstb_ovf", 32'(overflow_sticky), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rstb_frozen_idle", 32'(word_out), 32'h0000FFFF);
    push(2'd3, 12'h456);
    check("rstb_push_count", 32'(fifo_count), 32'd1);
    check("rstb_still_frozen", 32'(word_out), 32'h0000FFFF);
    cs = 1'b1;
    repeat (5) tick();
    check("rstb_no_pop", 32'(fifo_count), 32'd1);
    check("rstb_word_after", 32'(word_out), 32'h0000C456);
    check("rstb_isdata_after", 32'(word_is_data), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
